// File: rtl/tick_corr_window_if.sv
// Result bus from tick_corr_window toward the correlator readout.
// Carries one window result (agreement count + timestamp) per valid/ready
// transfer.
//   out_valid : result available
//   out_ready : consumer accepts result
//   out_count : agreements counted in the completed window
//   out_ts    : timestamp of the last tick in that window
interface tick_corr_window_if #(
  parameter int CNT_W = 32,
  parameter int TS_W  = 64
);
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic [TS_W-1:0]  out_ts;

  modport master (output out_valid, out_count, out_ts, input out_ready);
  modport slave  (input out_valid, out_count, out_ts, output out_ready);
endinterface

// File: rtl/tick_corr_window.sv
// tick_corr_window: on each clock-divider tick, samples two 1-bit channels and
// counts how often they agree (XNOR) over a window of window_len ticks. At
// window close the count and the tick timestamp go out on a valid/ready bus.
//   clk, rst   : clock, asynchronous active-high reset
//   enable     : run control; low drops the partial window and idles
//   tick       : one-cycle sample strobe
//   ch_a, ch_b : channel sample bits
//   window_len : ticks per window, latched at each window start
//   res        : result bus (master side)
//   overrun    : sticky, a finished window was dropped (result reg full)
//   busy       : high while a window is being integrated
module tick_corr_window #(
  parameter int CNT_W = 32,
  parameter int TS_W  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 tick,
  input  logic                 ch_a,
  input  logic                 ch_b,
  input  logic [CNT_W-1:0]     window_len,
  tick_corr_window_if.master   res,
  output logic                 overrun,
  output logic                 busy
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] len_q, acc, tcnt;
  logic [CNT_W-1:0] acc_nx, tcnt_nx;
  logic [TS_W-1:0]  ts, ts_nx;
  logic             tick_en, run_tick, win_close, res_free, xfer, start;

  // Timestamp follows every enabled tick, independent of the FSM state.
  assign tick_en   = enable & tick;
  assign ts_nx     = ts + {{(TS_W-1){1'b0}}, tick_en};

  assign run_tick  = (state == RUN) & tick_en;
  assign acc_nx    = acc + {{(CNT_W-1){1'b0}}, ~(ch_a ^ ch_b)};
  assign tcnt_nx   = tcnt + {{(CNT_W-1){1'b0}}, 1'b1};
  // Closing tick is the one that brings tcnt up to the latched length.
  assign win_close = run_tick & (tcnt_nx == len_q);
  assign start     = (state == IDLE) & enable & (window_len != '0);

  assign xfer      = res.out_valid & res.out_ready;
  // Result register can take a new value if empty or draining this cycle.
  assign res_free  = ~res.out_valid | res.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (!enable) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q         <= '0;
      acc           <= '0;
      tcnt          <= '0;
      ts            <= '0;
      overrun       <= 1'b0;
      res.out_valid <= 1'b0;
      res.out_count <= '0;
      res.out_ts    <= '0;
    end else begin
      ts <= ts_nx;

      if (start) begin
        len_q <= window_len;
        acc   <= '0;
        tcnt  <= '0;
      end else if (state == RUN && !enable) begin
        acc  <= '0;
        tcnt <= '0;
      end else if (win_close) begin
        // Back-to-back windows: next one starts on the following tick.
        len_q <= window_len;
        acc   <= '0;
        tcnt  <= '0;
      end else if (run_tick) begin
        acc  <= acc_nx;
        tcnt <= tcnt_nx;
      end

      if (win_close && res_free) begin
        res.out_valid <= 1'b1;
        res.out_count <= acc_nx;
        res.out_ts    <= ts_nx;
      end else begin
        if (xfer)      res.out_valid <= 1'b0;
        if (win_close) overrun       <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tick_corr_window.sv
module tb_tick_corr_window;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0, tick = 1'b0, ch_a = 1'b0, ch_b = 1'b0;
  logic [31:0] window_len = '0;
  logic        overrun, busy;
  int          checks = 0, errors = 0;

  tick_corr_window_if #(.CNT_W(32), .TS_W(64)) bus ();

  tick_corr_window #(.CNT_W(32), .TS_W(64)) dut (
    .clk(clk), .rst(rst), .enable(enable), .tick(tick),
    .ch_a(ch_a), .ch_b(ch_b), .window_len(window_len),
    .res(bus), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: keeps the current window's samples as a queue of
  // agree bits; a window closes when the queue holds len samples, and the
  // result is the number of agree bits in it.
  bit          m_run, m_valid, m_ovr, m_accept, m_loaded;
  int unsigned m_len;
  bit          m_win[$];
  logic [31:0] m_cnt;
  logic [63:0] m_ts, m_ots;

  function automatic int unsigned agree_count();
    int unsigned s = 0;
    foreach (m_win[i]) s += m_win[i];
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_valid = 0; m_ovr = 0; m_len = 0;
      m_win.delete(); m_cnt = '0; m_ts = '0; m_ots = '0;
    end else begin
      m_accept = m_valid && bus.out_ready;
      m_loaded = 0;
      if (enable && tick) m_ts = m_ts + 64'd1;
      if (m_run && !enable) begin
        m_run = 0;
        m_win.delete();
      end else if (m_run && tick) begin
        m_win.push_back(ch_a == ch_b);
        if (m_win.size() == m_len) begin
          if (!m_valid || m_accept) begin
            m_cnt = agree_count(); m_ots = m_ts; m_loaded = 1;
          end else m_ovr = 1;
          m_win.delete();
          m_len = window_len;
        end
      end else if (!m_run && enable && window_len != 0) begin
        m_run = 1; m_len = window_len; m_win.delete();
      end
      if (m_loaded) m_valid = 1;
      else if (m_accept) m_valid = 0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock; outputs compared against the model just after the edge.
  task automatic cyc();
    @(posedge clk); #1;
    chk("valid", bus.out_valid, m_valid);
    chk("count", bus.out_count, m_cnt);
    chk("ts",    bus.out_ts,    m_ots);
    chk("overrun", overrun, m_ovr);
    chk("busy",  busy, m_run);
  endtask

  // Two quiet cycles then a tick; returns just after the tick's edge.
  task automatic do_tick(input logic a, input logic b);
    cyc(); cyc();
    ch_a = a; ch_b = b; tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic do_reset();
    enable = 0; tick = 0; ch_a = 0; ch_b = 0; window_len = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1; #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_count", bus.out_count, 0);
    chk("rst_ts",    bus.out_ts, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy",  busy, 0);
    @(negedge clk); rst = 1'b0;
  endtask

  typedef struct {
    int unsigned len;
    bit          a;
    int          bmode;   // 0/1 constant, 2 = alternate 0,1,0,1 per tick
    int          nwin;
    int unsigned exp_cnt;
  } vec_t;

  vec_t vecs[6];
  longint unsigned tick_total;

  initial begin
    bus.out_ready = 1'b0;
    vecs[0] = '{4, 1'b1, 1, 2, 4};
    vecs[1] = '{8, 1'b1, 2, 2, 4};
    vecs[2] = '{5, 1'b0, 0, 1, 5};
    vecs[3] = '{6, 1'b1, 0, 1, 0};
    vecs[4] = '{1, 1'b1, 1, 3, 1};
    vecs[5] = '{6, 1'b0, 2, 2, 3};

    // Table-driven windows with the consumer always ready.
    do_reset();
    tick_total = 0;
    foreach (vecs[v]) begin
      window_len = vecs[v].len;
      enable = 1'b1; bus.out_ready = 1'b1;
      cyc();
      for (int w = 0; w < vecs[v].nwin; w++) begin
        for (int t = 0; t < int'(vecs[v].len); t++) begin
          do_tick(vecs[v].a, (vecs[v].bmode == 2) ? logic'(t[0]) : logic'(vecs[v].bmode[0]));
          tick_total++;
        end
        chk("tbl_valid", bus.out_valid, 1);
        chk("tbl_count", bus.out_count, vecs[v].exp_cnt);
        chk("tbl_ts",    bus.out_ts, tick_total);
      end
      cyc();
      chk("tbl_drop", bus.out_valid, 0);
      enable = 1'b0;
      cyc(); cyc();
    end

    // Consumer stalled across two closes: second result is dropped.
    do_reset();
    window_len = 2; enable = 1'b1; bus.out_ready = 1'b0;
    cyc();
    do_tick(1, 1); do_tick(1, 1);
    chk("ovr_valid1", bus.out_valid, 1);
    chk("ovr_count1", bus.out_count, 2);
    do_tick(0, 1); do_tick(0, 1);
    chk("ovr_flag",  overrun, 1);
    chk("ovr_hold_count", bus.out_count, 2);
    chk("ovr_hold_ts", bus.out_ts, 2);
    bus.out_ready = 1'b1;
    cyc();
    chk("ovr_drain", bus.out_valid, 0);
    chk("ovr_sticky", overrun, 1);

    // Window closes in the same cycle as a transfer.
    do_reset();
    window_len = 2; enable = 1'b1; bus.out_ready = 1'b0;
    cyc();
    do_tick(1, 1); do_tick(1, 1);
    do_tick(1, 0);
    cyc(); cyc();
    bus.out_ready = 1'b1; ch_a = 0; ch_b = 0; tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("same_valid", bus.out_valid, 1);
    chk("same_count", bus.out_count, 1);
    chk("same_ts", bus.out_ts, 4);
    chk("same_ovr", overrun, 0);
    cyc();
    chk("same_drain", bus.out_valid, 0);

    // enable dropped mid-window; timestamp keeps counting afterwards.
    do_reset();
    window_len = 5; enable = 1'b1; bus.out_ready = 1'b1;
    cyc();
    repeat (3) do_tick(1, 1);
    enable = 1'b0;
    cyc();
    chk("abort_busy", busy, 0);
    chk("abort_valid", bus.out_valid, 0);
    enable = 1'b1;
    cyc();
    repeat (5) do_tick(1, 1);
    chk("reen_valid", bus.out_valid, 1);
    chk("reen_count", bus.out_count, 5);
    chk("reen_ts", bus.out_ts, 8);

    // Asynchronous reset with a result pending, then window_len = 0.
    do_reset();
    window_len = 1; enable = 1'b1; bus.out_ready = 1'b0;
    cyc();
    do_tick(1, 1);
    cyc();
    chk("arst_pre_valid", bus.out_valid, 1);
    #3 rst = 1'b1; #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_count", bus.out_count, 0);
    chk("arst_ts", bus.out_ts, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk); rst = 1'b0;
    enable = 1'b1; window_len = 0; tick = 1'b1;
    repeat (4) begin
      cyc();
      chk("zero_len_busy", busy, 0);
    end
    tick = 1'b0;

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      enable = ($urandom_range(0, 29) != 0);
      tick = ($urandom_range(0, 2) == 0);
      ch_a = 1'($urandom);
      ch_b = 1'($urandom);
      window_len = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 6));
      bus.out_ready = ((i / 50) % 4 == 3) ? 1'b0 : ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
